// File: rtl/uart_pkg.sv
// Shared constants, TX state type and byte-merge helper for the uart_mmio register front end.
package uart_pkg;

    localparam logic [31:0] OFF_DATA    = 32'h0000_0000;
    localparam logic [31:0] OFF_IER     = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0005;
    localparam logic [31:0] OFF_CLKFREQ = 32'h0000_0100;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_TX_IDLE  = 5;
    localparam int ST_BUSY     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } tx_state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// Core data-bus port of uart_mmio: the core drives address/strobes, the block returns read_data/hit.
interface uart_mmio_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] read_data;
    logic        hit;

    modport master (output address, write_data, write_mask, write_enable, read_enable,
                    input  read_data, hit);
    modport slave  (input  address, write_data, write_mask, write_enable, read_enable,
                    output read_data, hit);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO only lands when a pop happens the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: DATA/STATUS/CLKFREQ registers, TX and RX byte FIFOs, TX launch FSM.
// Optional feature macro: UART_MMIO_IRQ_EN adds the IER register and the registered irq output.
module uart_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h1001_0000,
    parameter int          TX_DEPTH      = 8,
    parameter int          RX_DEPTH      = 8,
    parameter logic [31:0] CLKFREQ_RESET = 32'h0000_ffc0
) (
    input  logic              clk,
    input  logic              rst,
    uart_mmio_if.slave        bus,
    output logic [7:0]        uart_data,
    output logic              uart_write_enable,
    input  logic              uart_busy,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic [31:0]       clk_frequency
`ifdef UART_MMIO_IRQ_EN
    ,
    output logic              irq
`endif
);
    logic                       w_hit_data, w_hit_status, w_hit_clk, w_addr_ier;
    logic                       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_idle;
    logic                       w_rx_pop, w_rx_full, w_rx_empty, w_rx_avail;
    logic                       w_ovr_set, w_ovr_clr;
    logic [7:0]                 w_tx_dout, w_rx_dout;
    logic [$clog2(TX_DEPTH):0]  w_tx_count;
    logic [$clog2(RX_DEPTH):0]  w_rx_count;
    logic [31:0]                w_status, w_read_data;
    logic                       w_hit;
    tx_state_t                  r_state;
    logic [7:0]                 r_uart_data;
    logic                       r_uart_we;
    logic                       r_overrun;
    logic [31:0]                r_clkfreq;

    assign w_hit_data   = (bus.address == BASE_ADDR + OFF_DATA);
    assign w_hit_status = (bus.address == BASE_ADDR + OFF_STATUS);
    assign w_hit_clk    = (bus.address == BASE_ADDR + OFF_CLKFREQ);
    assign w_addr_ier   = (bus.address == BASE_ADDR + OFF_IER);

    assign w_tx_push  = bus.write_enable & bus.write_mask[0] & w_hit_data;
    assign w_tx_pop   = (r_state == IDLE) & ~w_tx_empty & ~uart_busy;
    assign w_tx_idle  = (w_tx_count == '0) & (r_state == IDLE) & ~uart_busy;
    assign w_rx_avail = (w_rx_count != '0);
    assign w_rx_pop   = bus.read_enable & w_hit_data & ~w_rx_empty;
    // A pop in the same cycle frees the slot, so only an unmatched push into a full FIFO is an overrun.
    assign w_ovr_set  = uart_rx_valid & w_rx_full & ~w_rx_pop;
    assign w_ovr_clr  = bus.read_enable & w_hit_status;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst), .push(w_tx_push), .pop(w_tx_pop), .din(bus.write_data[7:0]),
        .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst), .push(uart_rx_valid), .pop(w_rx_pop), .din(uart_rx_data),
        .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

`ifdef UART_MMIO_IRQ_EN
    logic [1:0] r_ier;
    logic       r_irq;

    // IER register and registered interrupt request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ier <= 2'b00;
            r_irq <= 1'b0;
        end else begin
            if (bus.write_enable & bus.write_mask[0] & w_addr_ier) begin
                r_ier <= bus.write_data[1:0];
            end
            r_irq <= (r_ier[0] & w_rx_avail) | (r_ier[1] & w_tx_idle) | (r_ier[0] & r_overrun);
        end
    end
    assign irq = r_irq;
`endif

    // STATUS word assembled from package bit indices.
    always_comb begin
        w_status              = 32'h0;
        w_status[ST_RX_AVAIL] = w_rx_avail;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_OVERRUN]  = r_overrun;
        w_status[ST_TX_IDLE]  = w_tx_idle;
        w_status[ST_BUSY]     = uart_busy;
    end

    // Combinational read mux and address-hit decode.
    always_comb begin
        w_read_data = 32'h0;
        w_hit       = 1'b0;
        if (w_hit_data) begin
            w_hit       = 1'b1;
            w_read_data = w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
        end else if (w_hit_status) begin
            w_hit       = 1'b1;
            w_read_data = w_status;
        end else if (w_hit_clk) begin
            w_hit       = 1'b1;
            w_read_data = r_clkfreq;
        end else if (w_addr_ier) begin
`ifdef UART_MMIO_IRQ_EN
            w_hit       = 1'b1;
            w_read_data = {30'h0, r_ier};
`else
            w_hit       = 1'b0;
            w_read_data = 32'h0;
`endif
        end else begin
            w_hit       = 1'b0;
            w_read_data = 32'h0;
        end
    end

    assign bus.read_data = w_read_data;
    assign bus.hit       = w_hit;

    // Sticky overrun flag; a same-cycle set beats the read clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (w_ovr_clr) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    // CLKFREQ register with per-byte write enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clkfreq <= CLKFREQ_RESET;
        end else if (bus.write_enable & w_hit_clk) begin
            r_clkfreq <= merge_bytes(r_clkfreq, bus.write_data, bus.write_mask);
        end else begin
            r_clkfreq <= r_clkfreq;
        end
    end

    // TX launch FSM; GUARD covers the cycle before the serializer raises busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_uart_data <= 8'hff;
            r_uart_we   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tx_pop) begin
                        r_state     <= SEND;
                        r_uart_data <= w_tx_dout;
                        r_uart_we   <= 1'b1;
                    end else begin
                        r_uart_we   <= 1'b0;
                    end
                end
                SEND: begin
                    r_state   <= GUARD;
                    r_uart_we <= 1'b0;
                end
                GUARD: begin
                    r_state   <= IDLE;
                    r_uart_we <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_uart_we <= 1'b0;
                end
            endcase
        end
    end

    assign uart_data         = r_uart_data;
    assign uart_write_enable = r_uart_we;
    assign clk_frequency     = r_clkfreq;
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: queue-based reference model, separate read and TX-launch monitors.
module tb_uart_mmio;
    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_IER  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h5;
    localparam logic [31:0] A_CLK  = BASE + 32'h100;

    typedef struct {
        string       nm;
        logic [31:0] exp;
        logic [31:0] mask;
        logic [31:0] clk;
        logic        hit;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_data;
    logic        uart_write_enable;
    logic        uart_busy;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic [31:0] clk_frequency;
`ifdef UART_MMIO_IRQ_EN
    logic        irq;
`endif

    uart_mmio_if bus();

    uart_mmio dut (
        .clk(clk), .rst(rst), .bus(bus),
        .uart_data(uart_data), .uart_write_enable(uart_write_enable), .uart_busy(uart_busy),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .clk_frequency(clk_frequency)
`ifdef UART_MMIO_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_pulse = -100;
    bit hold_busy = 1'b0;

    // reference model state
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_exp_q[$];
    rd_t         rd_q[$];
    bit          ovr;
    logic [31:0] clk_m;
    logic [1:0]  ier_m;
    logic [7:0]  st_mask;
    bit          tx_idle_exp;
    bit          tx_full_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, queue the expected read, then apply the cycle's effects to the model.
    task automatic cycle_op(input logic [31:0] a, input bit we, input logic [31:0] wd,
                            input logic [3:0] wm, input bit re, input bit rv, input logic [7:0] rd);
        rd_t e;
        bit  pop;
        bit  full_before;
        bit  set;
        @(negedge clk);
        bus.address = a; bus.write_enable = we; bus.write_data = wd; bus.write_mask = wm;
        bus.read_enable = re; uart_rx_valid = rv; uart_rx_data = rd;
        e.mask = 32'hffff_ffff; e.hit = 1'b1; e.exp = 32'h0; e.clk = clk_m;
        if (a == A_DATA) begin
            e.nm = "data_rd";
            e.exp = (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'h0;
        end else if (a == A_STAT) begin
            e.nm = "status_rd";
            e.exp = {24'h0, 1'b0, uart_busy, tx_idle_exp, 2'b00, ovr, tx_full_exp, (rx_q.size() != 0)};
            e.mask = {24'hff_ffff, st_mask};
        end else if (a == A_CLK) begin
            e.nm = "clkfreq_rd";
            e.exp = clk_m;
`ifdef UART_MMIO_IRQ_EN
        end else if (a == A_IER) begin
            e.nm = "ier_rd";
            e.exp = {30'h0, ier_m};
`endif
        end else begin
            e.nm = "unmapped_rd";
            e.hit = 1'b0;
        end
        rd_q.push_back(e);
        pop = re && (a == A_DATA) && (rx_q.size() != 0);
        full_before = (rx_q.size() == 8);
        if (pop) void'(rx_q.pop_front());
        set = 1'b0;
        if (rv) begin
            if (full_before && !pop) set = 1'b1;
            else rx_q.push_back(rd);
        end
        if (set) ovr = 1'b1;
        else if (re && a == A_STAT) ovr = 1'b0;
        if (we && a == A_DATA && wm[0] && tx_exp_q.size() < 8) tx_exp_q.push_back(wd[7:0]);
        if (we && a == A_CLK) begin
            for (int i = 0; i < 4; i++) if (wm[i]) clk_m[8*i +: 8] = wd[8*i +: 8];
        end
`ifdef UART_MMIO_IRQ_EN
        if (we && a == A_IER && wm[0]) ier_m = wd[1:0];
`endif
    endtask

    task automatic idle();
        cycle_op(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);
    endtask

    task automatic drain();
        int k = 0;
        while ((tx_exp_q.size() != 0 || uart_busy) && k < 300) begin
            idle();
            k++;
        end
        repeat (3) idle();
        chk("tx_drained", tx_exp_q.size(), 32'h0);
    endtask

    // Read monitor: compares read_data/hit/clk_frequency against the queued expectation.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rd_q.size() != 0) begin
                e = rd_q.pop_front();
                chk(e.nm, bus.read_data & e.mask, e.exp & e.mask);
                chk({e.nm, "_hit"}, {31'h0, bus.hit}, {31'h0, e.hit});
                chk("clk_frequency", clk_frequency, e.clk);
            end
        end
    end

    // TX monitor: every launch pulse must match the next expected byte, be spaced, and not occur under busy.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && uart_write_enable) begin
                if (tx_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_pulse: got byte %h expected no launch", uart_data);
                end else begin
                    chk("uart_data", {24'h0, uart_data}, {24'h0, tx_exp_q.pop_front()});
                end
                chk("launch_gap_ge3", {31'h0, (cyc - last_pulse) >= 3}, 32'h1);
                chk("launch_while_busy", {31'h0, uart_busy}, 32'h0);
                last_pulse = cyc;
            end
        end
    end

    // Serializer busy model: busy for 5 cycles after each pulse, or while hold_busy is set.
    initial begin
        int bcnt = 0;
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) bcnt = 0;
            else if (uart_write_enable) bcnt = 5;
            else if (bcnt > 0) bcnt--;
            uart_busy = hold_busy || (bcnt > 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] um;
        bit          rv;
        logic [7:0]  rb;
        int          k;
        rst = 1'b0;
        bus.address = 32'h0; bus.write_data = 32'h0; bus.write_mask = 4'h0;
        bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
        ovr = 1'b0; clk_m = 32'h0000_ffc0; ier_m = 2'b00;
        st_mask = 8'hff; tx_idle_exp = 1'b1; tx_full_exp = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_write_enable", {31'h0, uart_write_enable}, 32'h0);
        chk("rst_uart_data", {24'h0, uart_data}, 32'h0000_00ff);
        chk("rst_clk_frequency", clk_frequency, 32'h0000_ffc0);
        @(negedge clk);
        rst = 1'b1;
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
        cycle_op(A_CLK, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);

        // Three bytes with the busy model active.
        st_mask = 8'h45;
        cycle_op(A_DATA, 1'b1, 32'h41, 4'h1, 1'b0, 1'b0, 8'h0);
        cycle_op(A_DATA, 1'b1, 32'h42, 4'h1, 1'b0, 1'b0, 8'h0);
        cycle_op(A_DATA, 1'b1, 32'h43, 4'h1, 1'b0, 1'b0, 8'h0);
        drain();

        // Nine bytes while busy is held: FIFO fills, ninth dropped.
        hold_busy = 1'b1;
        idle(); idle();
        st_mask = 8'hff; tx_idle_exp = 1'b0;
        for (int i = 0; i < 9; i++)
            cycle_op(A_DATA, 1'b1, 32'h60 + i, 4'($urandom_range(0, 15)) | 4'b0001, 1'b0, 1'b0, 8'h0);
        tx_full_exp = 1'b1;
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);
        hold_busy = 1'b0; tx_full_exp = 1'b0; st_mask = 8'h45;
        drain();
        st_mask = 8'hff; tx_idle_exp = 1'b1;

        // RX overrun, readback and clear.
        for (int i = 0; i < 9; i++) cycle_op(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 8'h10 + 8'(i));
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 8; i++) cycle_op(A_DATA, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);

        // Full RX FIFO with simultaneous pop and push.
        for (int i = 0; i < 8; i++) cycle_op(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 8'h50 + 8'(i));
        cycle_op(A_DATA, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 8'h58);
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 8; i++) cycle_op(A_DATA, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);

        // Masked CLKFREQ write.
        cycle_op(A_CLK, 1'b1, 32'h0001_2345, 4'b0011, 1'b0, 1'b0, 8'h0);
        cycle_op(A_CLK, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
        #1;
        chk("clkfreq_masked", clk_frequency, 32'h0000_2345);

`ifdef UART_MMIO_IRQ_EN
        cycle_op(A_IER, 1'b1, 32'h1, 4'h1, 1'b0, 1'b0, 8'h0);
        idle();
        cycle_op(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 8'h77);
        idle(); #1; chk("irq_not_early", {31'h0, irq}, 32'h0);
        idle(); #1; chk("irq_set", {31'h0, irq}, 32'h1);
        cycle_op(A_DATA, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
        idle(); #1; chk("irq_hold", {31'h0, irq}, 32'h1);
        idle(); #1; chk("irq_clear", {31'h0, irq}, 32'h0);
        cycle_op(A_IER, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
`endif

        // Randomized mix against the model; TX-timing STATUS bits are masked here.
        st_mask = 8'h45;
        for (int n = 0; n < 400; n++) begin
            k  = $urandom_range(0, 10);
            rv = ($urandom_range(0, 3) == 0);
            rb = 8'($urandom);
            case (k)
                0, 1: begin
                    if (tx_exp_q.size() < 8)
                        cycle_op(A_DATA, 1'b1, $urandom, 4'($urandom), 1'b0, rv, rb);
                    else
                        cycle_op(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, rv, rb);
                end
                2, 3: cycle_op(A_DATA, 1'b0, 32'h0, 4'h0, 1'($urandom_range(0, 1)), rv, rb);
                4:    cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'($urandom_range(0, 1)), rv, rb);
                5:    cycle_op(A_STAT, 1'b1, $urandom, 4'hf, 1'b0, rv, rb);
                6:    cycle_op(A_CLK, 1'b1, $urandom, 4'($urandom), 1'b0, rv, rb);
                7:    cycle_op(A_CLK, 1'b0, 32'h0, 4'h0, 1'b1, rv, rb);
                8:    cycle_op(A_IER, 1'b0, 32'h0, 4'h0, 1'b1, rv, rb);
                9: begin
                    case ($urandom_range(0, 3))
                        0:       um = BASE + 32'h8;
                        1:       um = BASE + 32'h101;
                        2:       um = BASE + 32'h1;
                        default: um = 32'h0;
                    endcase
                    cycle_op(um, 1'b0, 32'h0, 4'h0, 1'b1, rv, rb);
                end
                default: cycle_op(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, rv, rb);
            endcase
        end
        drain();
        st_mask = 8'hff; tx_idle_exp = 1'b1;
        for (int i = 0; i < 10 && rx_q.size() != 0; i++)
            cycle_op(A_DATA, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0);
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);

        // Reset in the middle of a transfer, then confirm the block restarts cleanly.
        st_mask = 8'h45;
        cycle_op(A_DATA, 1'b1, 32'h81, 4'h1, 1'b0, 1'b0, 8'h0);
        cycle_op(A_DATA, 1'b1, 32'h82, 4'h1, 1'b0, 1'b1, 8'h33);
        cycle_op(A_CLK, 1'b1, 32'h1234_5678, 4'hf, 1'b0, 1'b0, 8'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        tx_exp_q.delete(); rx_q.delete();
        ovr = 1'b0; clk_m = 32'h0000_ffc0; ier_m = 2'b00;
        #1;
        chk("midrst_write_enable", {31'h0, uart_write_enable}, 32'h0);
        chk("midrst_uart_data", {24'h0, uart_data}, 32'h0000_00ff);
        chk("midrst_clk_frequency", clk_frequency, 32'h0000_ffc0);
`ifdef UART_MMIO_IRQ_EN
        chk("midrst_irq", {31'h0, irq}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        st_mask = 8'hff; tx_idle_exp = 1'b1;
        idle(); idle();
        cycle_op(A_STAT, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0);
        st_mask = 8'h45;
        cycle_op(A_DATA, 1'b1, 32'h99, 4'h1, 1'b0, 1'b0, 8'h0);
        drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
